// File: rtl/vin_pattern_gen.sv
// Video timing and test-pattern source: one beat of PIX_PER_CLK pixels per clock.
// Optional checker pattern for mode 3 is built only when VIN_PATTERN_CHECKER_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | outputs held at 0, waiting for en
// RUN    | h/v counters sweep the frame; en is re-examined at frame end
module vin_pattern_gen #(
    parameter int PIX_BITS    = 8,
    parameter int PIX_PER_CLK = 4,
    parameter int H_SYNC      = 2,
    parameter int H_BP        = 1,
    parameter int H_ACTIVE    = 4,
    parameter int H_FP        = 1,
    parameter int V_SYNC      = 1,
    parameter int V_BP        = 1,
    parameter int V_ACTIVE    = 3,
    parameter int V_FP        = 1,
    parameter int CHK_SHIFT   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [1:0]                      mode,
    input  logic [PIX_BITS-1:0]             solid_val,
    output logic                            vin_vsync,
    output logic                            vin_hsync,
    output logic                            vin_de,
    output logic [PIX_BITS*PIX_PER_CLK-1:0] vin_pixel,
    output logic                            frame_start,
    output logic [15:0]                     frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    // x/y only need the bits that reach a pixel value or the checker select
    localparam int XW      = (PIX_BITS > CHK_SHIFT + 1) ? PIX_BITS : CHK_SHIFT + 1;
    localparam int H_OFF   = H_SYNC + H_BP;
    localparam int V_OFF   = V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [1:0]    mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            h      <= '0;
            v      <= '0;
            mode_q <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state  <= S_RUN;
                        h      <= '0;
                        v      <= '0;
                        mode_q <= mode;
                    end
                end
                default: begin
                    if (h == H_LAST) begin
                        h <= '0;
                        if (v == V_LAST) begin
                            v <= '0;
                            if (en) mode_q <= mode;
                            else    state  <= S_IDLE;
                        end else begin
                            v <= v + 1'b1;
                        end
                    end else begin
                        h <= h + 1'b1;
                    end
                end
            endcase
        end
    end

    logic [31:0] h_ext;
    logic [31:0] v_ext;
    logic        vs_c;
    logic        hs_c;
    logic        de_c;
    logic        fs_c;
    logic [XW-1:0] x_base;
    logic [XW-1:0] y_c;
    logic [PIX_BITS*PIX_PER_CLK-1:0] pix_next;

    assign h_ext  = 32'(h);
    assign v_ext  = 32'(v);
    assign vs_c   = v_ext < 32'(V_SYNC);
    assign hs_c   = h_ext < 32'(H_SYNC);
    assign de_c   = (v_ext >= 32'(V_OFF)) && (v_ext < 32'(V_OFF + V_ACTIVE)) &&
                    (h_ext >= 32'(H_OFF)) && (h_ext < 32'(H_OFF + H_ACTIVE));
    assign fs_c   = (h == '0) && (v == '0);
    // Only the low XW bits matter, so the wrap outside the active window is harmless
    assign x_base = XW'(h_ext - 32'(H_OFF)) * XW'(PIX_PER_CLK);
    assign y_c    = XW'(v_ext - 32'(V_OFF));

    for (genvar g = 0; g < PIX_PER_CLK; g++) begin : g_lane
        logic [XW-1:0]       x_c;
        logic [PIX_BITS-1:0] lane_val;

        assign x_c = x_base + XW'(g);

        always_comb begin
            lane_val = solid_val;
            case (mode_q)
                2'd1: lane_val = x_c[PIX_BITS-1:0];
                2'd2: lane_val = y_c[PIX_BITS-1:0];
`ifdef VIN_PATTERN_CHECKER_EN
                2'd3: lane_val = {PIX_BITS{x_c[CHK_SHIFT] ^ y_c[CHK_SHIFT]}};
`else
                2'd3: lane_val = solid_val;
`endif
                default: lane_val = solid_val;
            endcase
        end

        assign pix_next[g*PIX_BITS +: PIX_BITS] = de_c ? lane_val : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vin_vsync   <= 1'b0;
            vin_hsync   <= 1'b0;
            vin_de      <= 1'b0;
            vin_pixel   <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else if (state == S_RUN) begin
            vin_vsync   <= vs_c;
            vin_hsync   <= hs_c;
            vin_de      <= de_c;
            vin_pixel   <= pix_next;
            frame_start <= fs_c;
            if (fs_c) frame_cnt <= frame_cnt + 16'd1;
        end else begin
            vin_vsync   <= 1'b0;
            vin_hsync   <= 1'b0;
            vin_de      <= 1'b0;
            vin_pixel   <= '0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vin_pattern_gen.sv
// Scoreboard bench for vin_pattern_gen: expected active beats are queued ahead of time
// and popped by a monitor on every beat with vin_de high; timing points are checked inline.
module tb_vin_pattern_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  solid_val;
    logic        vin_vsync;
    logic        vin_hsync;
    logic        vin_de;
    logic [31:0] vin_pixel;
    logic        frame_start;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int now_e  = 0;
    bit done   = 0;
    logic [31:0] exp_q[$];

    vin_pattern_gen dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_val(solid_val),
        .vin_vsync(vin_vsync), .vin_hsync(vin_hsync), .vin_de(vin_de),
        .vin_pixel(vin_pixel), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to edge n (relative to the current E0) and sample 1 ns later
    task automatic step_to(input int n);
        repeat (n - now_e) @(posedge clk);
        now_e = n;
        #1;
    endtask

    task automatic push_line(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    always @(negedge clk) begin
        if (vin_de) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h expected no active beat", vin_pixel);
            end else begin
                check("pixel_beat", vin_pixel, exp_q.pop_front());
            end
        end else begin
            check("pixel_zero_when_blank", vin_pixel, 32'h0);
        end
    end

    initial begin
        #20000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: got no completion expected completion within 20000 ns");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        rst = 1'b0; en = 1'b1; mode = 2'd1; solid_val = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vsync", {31'b0, vin_vsync}, 32'h0);
        check("rst_hsync", {31'b0, vin_hsync}, 32'h0);
        check("rst_de", {31'b0, vin_de}, 32'h0);
        check("rst_pixel", vin_pixel, 32'h0);
        check("rst_frame_start", {31'b0, frame_start}, 32'h0);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'h0);

        // frame 1: horizontal ramp on every active line
        repeat (3) push_line(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        // frame 2: vertical ramp
        push_line(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
        push_line(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
        push_line(32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202);
        // frame 3: checker (all three active lines fall in the first square row)
`ifdef VIN_PATTERN_CHECKER_EN
        repeat (3) push_line(32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
`else
        repeat (3) push_line(32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A);
`endif

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        now_e = 0;
        #1;
        step_to(1);
        check("e1_frame_start", {31'b0, frame_start}, 32'h1);
        check("e1_vsync", {31'b0, vin_vsync}, 32'h1);
        check("e1_hsync", {31'b0, vin_hsync}, 32'h1);
        check("e1_frame_cnt", {16'b0, frame_cnt}, 32'h1);
        step_to(2);
        check("e2_frame_start", {31'b0, frame_start}, 32'h0);
        check("e2_hsync", {31'b0, vin_hsync}, 32'h1);
        step_to(3);
        check("e3_hsync", {31'b0, vin_hsync}, 32'h0);
        step_to(9);
        check("e9_vsync", {31'b0, vin_vsync}, 32'h0);
        step_to(10);
        mode = 2'd2;
        step_to(19);
        check("e19_de", {31'b0, vin_de}, 32'h0);
        step_to(20);
        check("e20_de", {31'b0, vin_de}, 32'h1);
        step_to(24);
        check("e24_de", {31'b0, vin_de}, 32'h0);
        step_to(49);
        check("e49_frame_start", {31'b0, frame_start}, 32'h1);
        check("e49_frame_cnt", {16'b0, frame_cnt}, 32'h2);
        step_to(60);
        mode = 2'd3;
        step_to(97);
        check("e97_frame_start", {31'b0, frame_start}, 32'h1);
        check("e97_frame_cnt", {16'b0, frame_cnt}, 32'h3);
        step_to(100);
        en = 1'b0;
        step_to(144);
        check("e144_frame_start", {31'b0, frame_start}, 32'h0);
        step_to(145);
        check("e145_frame_start", {31'b0, frame_start}, 32'h0);
        check("e145_vsync", {31'b0, vin_vsync}, 32'h0);
        check("e145_hsync", {31'b0, vin_hsync}, 32'h0);
        check("e145_frame_cnt", {16'b0, frame_cnt}, 32'h3);
        step_to(150);
        check("e150_vsync", {31'b0, vin_vsync}, 32'h0);

        // frame 4 solid, mode switched to ramp mid-frame; frame 5 aborted by reset
        repeat (3) push_line(32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A);
        push_line(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h07060504);
        exp_q.push_back(32'h0B0A0908);
        mode = 2'd0;
        en = 1'b1;
        @(posedge clk);
        now_e = 0;
        #1;
        step_to(1);
        check("f4_frame_start", {31'b0, frame_start}, 32'h1);
        check("f4_frame_cnt", {16'b0, frame_cnt}, 32'h4);
        step_to(20);
        mode = 2'd1;
        step_to(49);
        check("f5_frame_start", {31'b0, frame_start}, 32'h1);
        check("f5_frame_cnt", {16'b0, frame_cnt}, 32'h5);
        step_to(78);
        #6;
        rst = 1'b0;
        #1;
        check("async_rst_de", {31'b0, vin_de}, 32'h0);
        check("async_rst_pixel", vin_pixel, 32'h0);
        check("async_rst_vsync", {31'b0, vin_vsync}, 32'h0);
        check("async_rst_hsync", {31'b0, vin_hsync}, 32'h0);
        check("async_rst_frame_cnt", {16'b0, frame_cnt}, 32'h0);
        #30;
        check("rst_hold_de", {31'b0, vin_de}, 32'h0);
        check("queue_drained", exp_q.size(), 32'h0);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
